// File: rtl/fetch_unit.sv
// IF stage: PC, variable-latency imem req/ack handshake, IF/ID register. Latency: IF/ID updates one edge after ack.
// Backpressure: if_en=0 parks one acked word in a hold buffer and drops imem_req. Optional counters: FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_en,
    input  logic        if_rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_next,
    output logic        if_valid,
    output logic        fetch_wait
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] drop_count
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pcn_q, inst_pcn_d;
    logic        valid_q, valid_d;
    logic        pending;
    logic        bubble;
    logic        load_mem;
    logic        load_hold;
    logic        drop_ack;
    logic        deliver;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign pending     = (state_q == S_FETCH) || (state_q == S_DROP);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        inst_pcn_d  = inst_pcn_q;
        valid_d     = valid_q;
        bubble      = 1'b0;
        load_mem    = 1'b0;
        load_hold   = 1'b0;
        drop_ack    = 1'b0;

        if (redirect) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            hold_inst_d = '0;
            hold_pc_d   = '0;
            drop_ack    = pending && imem_ack;
            bubble      = if_en;
            // The old request stays on the bus until its ack so memory never sees a torn handshake.
            if (pending && !imem_ack) begin
                state_d = S_DROP;
                if (state_q == S_FETCH) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    bubble  = if_en;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_q + STEP;
                        if (if_en) begin
                            load_mem = 1'b1;
                        end else begin
                            hold_inst_d = imem_rdata;
                            hold_pc_d   = pc_q;
                            state_d     = S_HOLD;
                        end
                    end else begin
                        bubble = if_en;
                    end
                end
                S_HOLD: begin
                    if (if_en) begin
                        load_hold = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_DROP: begin
                    bubble = if_en;
                    if (imem_ack) begin
                        drop_ack = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (if_rst || bubble) begin
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (load_mem) begin
            inst_d     = imem_rdata;
            inst_pc_d  = pc_q;
            inst_pcn_d = pc_q + STEP;
            valid_d    = 1'b1;
        end else if (load_hold) begin
            inst_d     = hold_inst_q;
            inst_pc_d  = hold_pc_q;
            inst_pcn_d = hold_pc_q + STEP;
            valid_d    = 1'b1;
        end
    end

    assign deliver = (load_mem || load_hold) && !if_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            inst_q      <= '0;
            inst_pc_q   <= RESET_PC;
            inst_pcn_q  <= RESET_PC + STEP;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            inst_pcn_q  <= inst_pcn_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req     = pending;
    assign imem_addr    = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign fetch_wait   = ((state_q == S_FETCH) && !imem_ack) || (state_q == S_DROP);
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign inst_pc_next = inst_pcn_q;
    assign if_valid     = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (deliver && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (drop_ack && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign drop_count  = drop_count_q;
`else
    logic unused_perf;
    assign unused_perf = deliver ^ drop_ack;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model feeds an expected queue, a monitor compares IF/ID.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_en = 1'b0, if_rst = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] inst, inst_pc, inst_pc_next;
    logic        if_valid, fetch_wait;

    logic        req_w, ack_w, valid_w, wait_w;
    logic [31:0] addr_w, rdata_w, inst_w, pc_w, pcn_w;
    logic        zero = 1'b0;
    logic        one = 1'b1;
    logic [31:0] zero32 = '0;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, fetch_count_w;
    logic [15:0] drop_count, drop_count_w;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h3C00_0000;
    endfunction

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .if_en(if_en), .if_rst(if_rst), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
        .inst_pc_next(inst_pc_next), .if_valid(if_valid), .fetch_wait(fetch_wait)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .drop_count(drop_count)
`endif
    );

    assign ack_w   = req_w;
    assign rdata_w = mem_word(addr_w);

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst(rst), .if_en(one), .if_rst(zero), .redirect(zero),
        .redirect_pc(zero32), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .inst(inst_w), .inst_pc(pc_w),
        .inst_pc_next(pcn_w), .if_valid(valid_w), .fetch_wait(wait_w)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count_w), .drop_count(drop_count_w)
`endif
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcn;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    logic  mon_on = 1'b0;

    // Reference model: next fetch address, parked word, stale outstanding request.
    logic [31:0] np = 32'h0;
    item_t       held;
    logic        held_v = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] stale_addr = '0;
    logic        idle = 1'b0;
    int          lat_cnt = 0;
    int          lat_lo = 0, lat_hi = 0;
    int          n_deliv = 0, n_drop = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic deliver(input item_t w);
        if (!if_rst) begin
            exp_q.push_back(w);
            n_deliv++;
        end
    endtask

    task automatic cycle(input int mode);
        logic  exp_req;
        item_t w;
        if_en       = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if_rst      = (mode == 2) && ($urandom_range(0, 19) == 0);
        redirect    = (mode == 2) && ($urandom_range(0, 19) == 0);
        redirect_pc = (mode == 3) ? 32'h0000_0102 : ($urandom & 32'h0000_0FFF);
        if (mode == 3) redirect = 1'b1;
        if (imem_req && lat_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            lat_cnt    = $urandom_range(lat_lo, lat_hi);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) lat_cnt--;
        end
        #1;
        exp_req = !idle && !held_v;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, stale ? stale_addr : np);
        check("fetch_wait", {31'b0, fetch_wait}, {31'b0, exp_req && (!imem_ack || stale)});

        if (redirect) begin
            held_v = 1'b0;
            if (exp_req && !imem_ack) begin
                if (!stale) stale_addr = np;
                stale = 1'b1;
            end else begin
                if (imem_ack) n_drop++;
                stale = 1'b0;
            end
            np = {redirect_pc[31:2], 2'b00};
        end else if (imem_ack && stale) begin
            stale = 1'b0;
            n_drop++;
        end else if (imem_ack) begin
            w  = '{inst: mem_word(np), pc: np, pcn: np + 32'd4};
            np = np + 32'd4;
            if (if_en) deliver(w);
            else begin
                held   = w;
                held_v = 1'b1;
            end
        end else if (held_v && if_en) begin
            deliver(held);
            held_v = 1'b0;
        end
        idle = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: tracks what IF/ID must contain after every edge.
    initial begin : monitor
        item_t       cur;
        logic        cur_v;
        cur   = '{inst: 32'h0, pc: 32'h0, pcn: 32'h4};
        cur_v = 1'b0;
        wait (mon_on);
        forever begin
            @(posedge clk);
            #1;
            if (if_rst) begin
                cur_v    = 1'b0;
                cur.inst = '0;
            end else if (if_en) begin
                if (exp_q.size() > 0) begin
                    cur   = exp_q.pop_front();
                    cur_v = 1'b1;
                end else begin
                    cur_v    = 1'b0;
                    cur.inst = '0;
                end
            end
            check("if_valid", {31'b0, if_valid}, {31'b0, cur_v});
            check("inst", inst, cur.inst);
            if (cur_v) begin
                check("inst_pc", inst_pc, cur.pc);
                check("inst_pc_next", inst_pc_next, cur.pcn);
            end
        end
    end

    // Wrap-around instance: zero-wait memory from RESET_PC=FFFF_FFFC.
    initial begin : wrap_mon
        logic [31:0] got[3];
        int          n;
        n = 0;
        wait (mon_on);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (valid_w && n < 3) begin
                got[n] = pc_w;
                check("wrap_inst", inst_w, mem_word(pc_w));
                n++;
`ifdef FETCH_PERF_EN
                if (n == 2) check("wrap_fetch_count", fetch_count_w, 32'd2);
`endif
            end
        end
        check("wrap_count", n, 3);
        if (n == 3) begin
            check("wrap_pc0", got[0], 32'hFFFF_FFFC);
            check("wrap_pc1", got[1], 32'h0000_0000);
            check("wrap_pc2", got[2], 32'h0000_0004);
        end
    end

    initial begin : stim
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_pc_next", inst_pc_next, 32'h4);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_wait", {31'b0, fetch_wait}, 32'h0);
        check("rst_wrap_pcn", pcn_w, 32'h0000_0000);
`ifdef FETCH_PERF_EN
        check("rst_fetch_count", fetch_count, 32'h0);
        check("rst_drop_count", {16'h0, drop_count}, 32'h0);
`endif
        @(negedge clk);
        rst    = 1'b0;
        idle   = 1'b1;
        mon_on = 1'b1;

        lat_lo = 0; lat_hi = 0; lat_cnt = 0;
        for (int i = 0; i < 20; i++) cycle(0);
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 30; i++) cycle(1);
        // Redirect to an unaligned target while a 3-cycle request is in flight.
        while (!(imem_req && lat_cnt > 0 && !stale)) cycle(1);
        cycle(3);
        for (int i = 0; i < 12; i++) cycle(1);
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) cycle(2);
        if_rst = 1'b0; redirect = 1'b0; if_en = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, n_deliv);
        check("drop_count", {16'h0, drop_count}, n_drop);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
